// File: rtl/llpm_pipeline_pkg.sv
// rtl/llpm_pipeline_pkg.sv - shared helpers for the LI pipeline merge/fork/demux stages
//
// sel_width(n) : bits needed to index n channels, never less than 1.
// debug_reg()  : simulation register observation hook.
package llpm_pipeline_pkg;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Folds the observed registers into one bit so every argument is consumed;
    // callers discard the result.
    function automatic logic debug_reg(
        input string       name,
        input logic        valid1,
        input logic [63:0] data1,
        input logic        valid2,
        input logic [63:0] data2
    );
        return (name.len() > 0) ^ valid1 ^ valid2 ^ (^data1) ^ (^data2);
    endfunction

endpackage

// File: rtl/pipeline_rr_merge_rr_picker.sv
// rtl/pipeline_rr_merge_rr_picker.sv - combinational round-robin picker
//
// Ports:
//   req    in  NumInputs  per-channel request
//   ptr    in  SelW       first channel to consider
//   enable in  1          when low no grant is issued
//   grant  out NumInputs  one-hot grant (all zeros when nothing granted)
//   winner out SelW       index of the granted channel
//   any    out 1          a grant was issued
module rr_picker
    import llpm_pipeline_pkg::*;
#(
    parameter int  NumInputs = 4,
    localparam int SelW      = sel_width(NumInputs)
) (
    input  logic [NumInputs-1:0] req,
    input  logic [SelW-1:0]      ptr,
    input  logic                 enable,
    output logic [NumInputs-1:0] grant,
    output logic [SelW-1:0]      winner,
    output logic                 any
);

    int idx;

    // Scan ptr, ptr+1, ... modulo NumInputs; the first requester wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        if (enable) begin
            for (int k = 0; k < NumInputs; k++) begin
                idx = (int'(ptr) + k) % NumInputs;
                if (!any && req[idx]) begin
                    any        = 1'b1;
                    winner     = SelW'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_rr_merge.sv
// rtl/pipeline_rr_merge.sv - round-robin merge of NumInputs LI channels into one
//
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   d            NumInputs*Width packed input data, channel i at [i*Width +: Width]
//   d_valid      per-channel token valid
//   d_bp         per-channel backpressure (0 = token consumed this cycle)
//   q, q_sel     output data and source channel index (registered)
//   q_valid      output token valid (registered)
//   q_bp         downstream backpressure
module pipeline_rr_merge
    import llpm_pipeline_pkg::*;
#(
    parameter string Name      = "",
    parameter int    Width     = 8,
    parameter int    NumInputs = 4,
    localparam int   SelW      = sel_width(NumInputs)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NumInputs*Width-1:0] d,
    input  logic [NumInputs-1:0]       d_valid,
    output logic [NumInputs-1:0]       d_bp,
    output logic [Width-1:0]           q,
    output logic [SelW-1:0]            q_sel,
    output logic                       q_valid,
    input  logic                       q_bp
);

    logic             valid1_q, valid1_d, valid2_q, valid2_d;
    logic [Width-1:0] data1_q, data1_d, data2_q, data2_d;
    logic [SelW-1:0]  sel1_q, sel1_d, sel2_q, sel2_d;
    logic [SelW-1:0]  ptr_q, ptr_d;

    logic                 full, incoming, outgoing, any;
    logic [NumInputs-1:0] grant;
    logic [SelW-1:0]      winner;
    logic [Width-1:0]     new_data;

    // Grants depend only on d_valid/ptr/full/resetn, never on q_bp: the
    // second slot absorbs the token accepted while the stall propagates.
    assign full = valid1_q & valid2_q;

    rr_picker #(.NumInputs(NumInputs)) u_picker (
        .req    (d_valid),
        .ptr    (ptr_q),
        .enable (resetn & ~full),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    assign d_bp     = ~grant;
    assign incoming = any;
    assign outgoing = valid1_q & ~q_bp;

    always_comb begin
        new_data = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (winner == SelW'(i)) begin
                new_data = d[i*Width +: Width];
            end
        end
    end

    // Pointer moves just past the winner, wrapping for non-power-of-2 counts.
    always_comb begin
        ptr_d = ptr_q;
        if (incoming) begin
            ptr_d = (winner == SelW'(NumInputs - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        valid1_d = valid1_q;
        data1_d  = data1_q;
        sel1_d   = sel1_q;
        valid2_d = valid2_q;
        data2_d  = data2_q;
        sel2_d   = sel2_q;
        case ({incoming, outgoing})
            2'b01: begin
                valid1_d = valid2_q;
                data1_d  = data2_q;
                sel1_d   = sel2_q;
                valid2_d = 1'b0;
            end
            2'b10: begin
                if (valid1_q) begin
                    valid2_d = 1'b1;
                    data2_d  = new_data;
                    sel2_d   = winner;
                end else begin
                    valid1_d = 1'b1;
                    data1_d  = new_data;
                    sel1_d   = winner;
                end
            end
            2'b11: begin
                // valid2 set here cannot occur (full blocks grants); kept for safety.
                if (valid2_q) begin
                    data1_d = data2_q;
                    sel1_d  = sel2_q;
                    data2_d = new_data;
                    sel2_d  = winner;
                end else begin
                    valid1_d = 1'b1;
                    data1_d  = new_data;
                    sel1_d   = winner;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            ptr_q    <= ptr_d;
        end
    end

    // Payload registers carry no reset; they are qualified by valid1/valid2.
    always_ff @(posedge clk) begin
        data1_q <= data1_d;
        sel1_q  <= sel1_d;
        data2_q <= data2_d;
        sel2_q  <= sel2_d;
    end

    assign q       = data1_q;
    assign q_sel   = sel1_q;
    assign q_valid = valid1_q;

    always_ff @(posedge clk) begin
        void'(debug_reg(Name, valid1_q, 64'(data1_q), valid2_q, 64'(data2_q)));
    end

endmodule

// File: tb/tb_pipeline_rr_merge.sv
// tb/tb_pipeline_rr_merge.sv - self-checking bench for pipeline_rr_merge (4- and 3-input instances)
module tb_pipeline_rr_merge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       q_bp;
    logic [3:0] vld;
    logic [7:0] dat [2][4];

    logic [31:0] d4;
    logic [23:0] d3;
    logic [3:0]  d_bp4;
    logic [2:0]  d_bp3;
    logic [7:0]  q4, q3;
    logic [1:0]  q_sel4, q_sel3;
    logic        q_valid4, q_valid3;

    assign d4 = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
    assign d3 = {dat[1][2], dat[1][1], dat[1][0]};

    pipeline_rr_merge #(.Width(8), .NumInputs(4)) dut4 (
        .clk(clk), .resetn(resetn), .d(d4), .d_valid(vld), .d_bp(d_bp4),
        .q(q4), .q_sel(q_sel4), .q_valid(q_valid4), .q_bp(q_bp)
    );

    pipeline_rr_merge #(.Width(8), .NumInputs(3)) dut3 (
        .clk(clk), .resetn(resetn), .d(d3), .d_valid(vld[2:0]), .d_bp(d_bp3),
        .q(q3), .q_sel(q_sel3), .q_valid(q_valid3), .q_bp(q_bp)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state per instance (0: 4 inputs, 1: 3 inputs)
    int         mptr [2];
    int         cnt  [2];
    int         win  [2];
    logic [9:0] sb   [2][$];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[dut%0d] @%0t: observed %h expected %h", tag, k, $time, obs, exp);
        end
    endtask

    // Inputs are already driven (called just after a negedge).
    task automatic cycle();
        logic [3:0] bp_obs, bp_exp;
        logic       qv;
        logic [7:0] qd;
        logic [1:0] qs;
        bit         out;
        #1;
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 4 : 3;
            win[k] = -1;
            if (resetn && cnt[k] < 2) begin
                for (int j = 0; j < n; j++) begin
                    int idx;
                    idx = (mptr[k] + j) % n;
                    if (win[k] < 0 && vld[idx]) win[k] = idx;
                end
            end
            bp_exp = 4'((1 << n) - 1);
            if (win[k] >= 0) bp_exp[win[k]] = 1'b0;
            if (k == 0) begin
                bp_obs = d_bp4; qv = q_valid4; qd = q4; qs = q_sel4;
            end else begin
                bp_obs = {1'b0, d_bp3}; qv = q_valid3; qd = q3; qs = q_sel3;
            end
            chk("d_bp", k, 32'(bp_obs), 32'(bp_exp));
            chk("q_valid", k, 32'(qv), 32'(cnt[k] > 0));
            if (cnt[k] > 0) begin
                chk("q", k, 32'(qd), 32'(sb[k][0][7:0]));
                chk("q_sel", k, 32'(qs), 32'(sb[k][0][9:8]));
            end
            if (win[k] >= 0) sb[k].push_back({2'(win[k]), dat[k][win[k]]});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 4 : 3;
            if (!resetn) begin
                sb[k].delete();
                cnt[k]  = 0;
                mptr[k] = 0;
            end else begin
                out = (cnt[k] > 0) && !q_bp;
                if (out) begin
                    void'(sb[k].pop_front());
                    cnt[k]--;
                end
                if (win[k] >= 0) begin
                    mptr[k] = (win[k] + 1) % n;
                    dat[k][win[k]] = dat[k][win[k]] + 8'h10;
                    cnt[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int ncyc);
        for (int c = 0; c < ncyc; c++) cycle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mptr[k] = 0;
            cnt[k]  = 0;
            for (int i = 0; i < 4; i++) dat[k][i] = 8'hA0 + 8'(i);
        end
        resetn = 1'b0;
        q_bp   = 1'b0;
        vld    = 4'b1111;
        @(posedge clk);
        @(negedge clk);

        // Reset held with every channel requesting
        run(3);

        // Fairness (4 inputs) and pointer wrap (3 inputs)
        resetn = 1'b1;
        run(8);

        // Skip: only channels 1 and 3 valid, pointer restarted at 0
        resetn = 1'b0;
        run(1);
        resetn = 1'b1;
        vld    = 4'b1010;
        run(6);

        vld = 4'b0000;
        run(3);

        // Stall/fill on channel 2, then release
        q_bp = 1'b1;
        vld  = 4'b0100;
        run(5);
        q_bp = 1'b0;
        run(6);
        vld = 4'b0000;
        run(2);

        // Reset mid-stream with both slots full
        q_bp = 1'b1;
        vld  = 4'b1111;
        run(3);
        resetn = 1'b0;
        run(1);
        resetn = 1'b1;
        q_bp   = 1'b0;
        vld    = 4'b0000;
        run(3);

        // Random traffic and backpressure
        for (int c = 0; c < 40; c++) begin
            vld  = 4'($urandom_range(0, 15));
            q_bp = ($urandom_range(0, 3) == 0);
            cycle();
        end
        vld  = 4'b0000;
        q_bp = 1'b0;
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
